// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: Moore FSM that sequences the alarm clock's 4-digit key
// buffer. It turns keypad digits into single-cycle shift strobes, counts the
// digits entered, issues load strobes for the alarm register or time counter
// when a button is pressed, drives the display-select flags and abandons an
// idle entry after TIMEOUT_SEC one_second pulses.
//
// Optional feature: define KEY_ENTRY_GUARD_EN to accept a button press in
// KEY_ENTRY only once all four digits have been entered.
module key_entry_ctrl #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_a,
  output logic       show_new_time,
  output logic [2:0] digit_count
);

  typedef enum logic [2:0] {
    SHOW_TIME,
    KEY_STORED,
    KEY_WAITED,
    KEY_ENTRY,
    SHOW_ALARM,
    SET_ALARM_TIME,
    SET_CURRENT_TIME
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] sec_count;
  logic       is_digit;
  logic       timeout;
  logic       buttons_ok;
  logic       counting;

  // Codes 0..9 are digits; NOKEY (4'hA) and 4'hB..4'hF all count as no key.
  assign is_digit = (key <= 4'd9);
  assign timeout  = (sec_count == 4'(TIMEOUT_SEC));
  assign counting = (state == KEY_WAITED) || (state == KEY_ENTRY);

`ifdef KEY_ENTRY_GUARD_EN
  // A partial entry must never reach the alarm register or time counter.
  assign buttons_ok = (digit_count == 3'd4);
`else
  assign buttons_ok = 1'b1;
`endif

  // State register; reset aborts any entry or pending strobe immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SHOW_TIME;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, priority top-down within each state.
  always_comb begin
    state_next = state;
    case (state)
      SHOW_TIME: begin
        if (alarm_button)  state_next = SHOW_ALARM;
        else if (is_digit) state_next = KEY_STORED;
      end
      KEY_STORED: state_next = KEY_WAITED;
      KEY_WAITED: begin
        if (!is_digit)    state_next = KEY_ENTRY;
        else if (timeout) state_next = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button && buttons_ok)     state_next = SET_ALARM_TIME;
        else if (time_button && buttons_ok) state_next = SET_CURRENT_TIME;
        else if (is_digit)                  state_next = KEY_STORED;
        else if (timeout)                   state_next = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!alarm_button) state_next = SHOW_TIME;
      end
      SET_ALARM_TIME:   state_next = SHOW_TIME;
      SET_CURRENT_TIME: state_next = SHOW_TIME;
      default:          state_next = SHOW_TIME;
    endcase
  end

  // Moore output decode straight from the state register.
  always_comb begin
    shift         = (state == KEY_STORED);
    load_new_a    = (state == SET_ALARM_TIME);
    load_new_c    = (state == SET_CURRENT_TIME);
    show_a        = (state == SHOW_ALARM);
    show_new_time = (state == KEY_STORED) || (state == KEY_WAITED) ||
                    (state == KEY_ENTRY);
  end

  // Digit counter: one increment per shift strobe, saturating at four; held
  // at zero for as long as the FSM is (or is about to be) in SHOW_TIME.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digit_count <= 3'd0;
    end else if (state == SHOW_TIME || state_next == SHOW_TIME) begin
      digit_count <= 3'd0;
    end else if (state == KEY_STORED && digit_count != 3'd4) begin
      digit_count <= digit_count + 3'd1;
    end
  end

  // Idle timer: counts seconds only while waiting for the next key and
  // clears elsewhere, so each stored key restarts it from zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sec_count <= 4'd0;
    end else if (counting) begin
      if (one_second && !timeout) begin
        sec_count <= sec_count + 4'd1;
      end
    end else begin
      sec_count <= 4'd0;
    end
  end

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Bench for key_entry_ctrl: a table of single-cycle vectors for the main
// entry/alarm-display flows, followed by hand-written multi-cycle sequences
// for held keys, timeout, button priority, the entry guard and async reset.
module tb_key_entry_ctrl;

  logic       clock;
  logic       reset;
  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       shift;
  logic       load_new_a;
  logic       load_new_c;
  logic       show_a;
  logic       show_new_time;
  logic [2:0] digit_count;

  int n_checks = 0;
  int n_fail   = 0;
  int sh_cnt   = 0;
  int la_cnt   = 0;
  int lc_cnt   = 0;

  typedef struct {
    logic [3:0] k;
    logic       ab;
    logic       tbt;
    logic       os;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  key_entry_ctrl #(.TIMEOUT_SEC(10)) dut (
    .clock        (clock),
    .reset        (reset),
    .one_second   (one_second),
    .key          (key),
    .alarm_button (alarm_button),
    .time_button  (time_button),
    .shift        (shift),
    .load_new_a   (load_new_a),
    .load_new_c   (load_new_c),
    .show_a       (show_a),
    .show_new_time(show_new_time),
    .digit_count  (digit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packs expected outputs as {shift, load_a, load_c, show_a, show_new, count}.
  function automatic logic [7:0] ov(input logic sh, la, lc, sa, snt,
                                    input logic [2:0] dc);
    return {sh, la, lc, sa, snt, dc};
  endfunction

  function automatic logic [7:0] outs();
    return {shift, load_new_a, load_new_c, show_a, show_new_time, digit_count};
  endfunction

  function automatic void add(input logic [3:0] k, input logic ab, tbt, os,
                              input logic [7:0] exp);
    vec_t v;
    v.k = k; v.ab = ab; v.tbt = tbt; v.os = os; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock once, sample 1 ns after the edge.
  task automatic step(input logic [3:0] k, input logic ab = 1'b0,
                      input logic tbt = 1'b0, input logic os = 1'b0);
    key = k; alarm_button = ab; time_button = tbt; one_second = os;
    @(posedge clock);
    #1;
    if (shift)      sh_cnt++;
    if (load_new_a) la_cnt++;
    if (load_new_c) lc_cnt++;
  endtask

  task automatic enter_digit(input logic [3:0] d);
    step(d); step(d); step(d);
    step(4'hA); step(4'hA);
  endtask

  task automatic do_reset();
    key = 4'hA; alarm_button = 0; time_button = 0; one_second = 0;
    reset = 1'b1;
    @(posedge clock); @(posedge clock);
    #1;
    reset = 1'b0;
    sh_cnt = 0; la_cnt = 0; lc_cnt = 0;
  endtask

  initial begin
    logic [3:0] digits [4];
    digits[0] = 4'd1; digits[1] = 4'd2; digits[2] = 4'd3; digits[3] = 4'd0;

    // Alarm entry: four digits held 3 cycles with 2-cycle NOKEY gaps.
    for (int i = 0; i < 4; i++) begin
      add(digits[i], 0, 0, 0, ov(1, 0, 0, 0, 1, 3'(i)));
      add(digits[i], 0, 0, 0, ov(0, 0, 0, 0, 1, 3'(i + 1)));
      add(digits[i], 0, 0, 0, ov(0, 0, 0, 0, 1, 3'(i + 1)));
      add(4'hA,      0, 0, 0, ov(0, 0, 0, 0, 1, 3'(i + 1)));
      add(4'hA,      0, 0, 0, ov(0, 0, 0, 0, 1, 3'(i + 1)));
    end
    add(4'hA, 1, 0, 0, ov(0, 1, 0, 0, 0, 3'd4));
    add(4'hA, 0, 0, 0, ov(0, 0, 0, 0, 0, 3'd0));
    // Alarm display: button beats a digit in SHOW_TIME, drops after release.
    add(4'd5, 1, 0, 0, ov(0, 0, 0, 1, 0, 3'd0));
    add(4'd5, 1, 0, 0, ov(0, 0, 0, 1, 0, 3'd0));
    add(4'hA, 0, 0, 0, ov(0, 0, 0, 0, 0, 3'd0));
    add(4'hA, 0, 0, 0, ov(0, 0, 0, 0, 0, 3'd0));
    // Codes B..F are no-key; time_button alone does nothing in SHOW_TIME.
    add(4'hF, 0, 0, 0, ov(0, 0, 0, 0, 0, 3'd0));
    add(4'hB, 0, 1, 1, ov(0, 0, 0, 0, 0, 3'd0));

    reset = 1'b1;
    key = 4'hA; alarm_button = 0; time_button = 0; one_second = 0;
    #1;
    @(posedge clock); @(posedge clock);
    #1;
    chk("reset_outputs", int'(outs()), 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].k, vecs[i].ab, vecs[i].tbt, vecs[i].os);
      chk($sformatf("vec%0d", i), int'(outs()), int'(vecs[i].exp));
    end

    // Held key: one shift only; buttons ignored while waiting for release.
    do_reset();
    for (int i = 0; i < 20; i++) step(4'd7, 1'b0, (i >= 15), 1'b0);
    chk("held_shift_count", sh_cnt, 1);
    chk("held_no_load_c", lc_cnt, 0);
    chk("held_waiting", int'(outs()), int'(ov(0, 0, 0, 0, 1, 3'd1)));
    step(4'hA);
    chk("held_release_entry", int'(outs()), int'(ov(0, 0, 0, 0, 1, 3'd1)));

    // Timeout: nine pulses keep the entry, the tenth abandons it.
    do_reset();
    step(4'd3); step(4'd3); step(4'hA);
    for (int i = 0; i < 9; i++) begin
      step(4'hA, 0, 0, 1); step(4'hA);
    end
    chk("nine_pulses_entry", int'(outs()), int'(ov(0, 0, 0, 0, 1, 3'd1)));
    step(4'hA, 0, 0, 1);
    chk("tenth_pulse_edge", int'(show_new_time), 1);
    step(4'hA);
    chk("timeout_show_time", int'(outs()), 0);
    chk("timeout_no_loads", la_cnt + lc_cnt, 0);

    // A pulse coinciding with a digit is discarded; timer restarts.
    do_reset();
    step(4'd4); step(4'd4); step(4'hA);
    for (int i = 0; i < 9; i++) step(4'hA, 0, 0, 1);
    step(4'd5, 0, 0, 1);
    chk("pulse_with_digit_shift", int'(shift), 1);
    step(4'd5); step(4'hA);
    for (int i = 0; i < 9; i++) step(4'hA, 0, 0, 1);
    chk("restart_nine_entry", int'(outs()), int'(ov(0, 0, 0, 0, 1, 3'd2)));
    step(4'hA, 0, 0, 1); step(4'hA);
    chk("restart_tenth_timeout", int'(outs()), 0);

    // Both buttons after four digits: alarm wins.
    do_reset();
    for (int i = 0; i < 4; i++) enter_digit(4'(i + 6));
    chk("four_digits_count", int'(digit_count), 4);
    step(4'hA, 1, 1, 0);
    chk("both_buttons_strobe", int'(outs()), int'(ov(0, 1, 0, 0, 0, 3'd4)));
    step(4'hA);
    chk("both_buttons_after", int'(outs()), 0);
    chk("both_buttons_counts", la_cnt * 16 + lc_cnt, 16);

    // Partial entry followed by time_button.
    do_reset();
    enter_digit(4'd2); enter_digit(4'd8);
    step(4'hA, 0, 1, 0);
`ifdef KEY_ENTRY_GUARD_EN
    chk("guard_blocked", int'(outs()), int'(ov(0, 0, 0, 0, 1, 3'd2)));
    step(4'hA);
    chk("guard_stays_entry", int'(outs()), int'(ov(0, 0, 0, 0, 1, 3'd2)));
    chk("guard_no_load_c", lc_cnt, 0);
`else
    chk("partial_load_c", int'(outs()), int'(ov(0, 0, 1, 0, 0, 3'd2)));
    step(4'hA);
    chk("partial_after", int'(outs()), 0);
    chk("partial_load_c_once", lc_cnt, 1);
`endif

    // Asynchronous reset in the middle of an entry.
    do_reset();
    enter_digit(4'd9); enter_digit(4'd4);
    chk("pre_reset_entry", int'(outs()), int'(ov(0, 0, 0, 0, 1, 3'd2)));
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_now", int'(outs()), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(4'hA, 1, 0, 0);
    chk("post_reset_show_time", int'(outs()), int'(ov(0, 0, 0, 1, 0, 3'd0)));
    step(4'hA);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
